// File: rtl/fetch_unit_if.sv
// Fetch-stage shared types and the fetch <-> IQ / imem / predictor bundle.
// Master side is the fetch unit; slave side is memory, IQ and predictor.
`ifndef NOOP_INST
`define NOOP_INST 32'h0000_0013
`endif

package fetch_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pred_pc;
    logic        prediction;
  } branch_inst_t;

  typedef struct packed {
    logic         valid_inst;
    logic [63:0]  npc;
    logic [31:0]  ir;
    branch_inst_t branch_inst;
  } INST_Q;

endpackage

interface fetch_unit_if #(
  parameter int MEM_TAG_W = 4
);
  import fetch_pkg::*;

  logic                 inst_queue_full;
  logic                 branch_incorrect;
  logic [63:0]          branch_target_pc;
  logic                 bp_taken;
  logic [63:0]          bp_target;
  logic [MEM_TAG_W-1:0] Imem2proc_response;
  logic [63:0]          Imem2proc_data;
  logic [MEM_TAG_W-1:0] Imem2proc_tag;
  bus_cmd_t             proc2Imem_command;
  logic [63:0]          proc2Imem_addr;
  logic [63:0]          fetch_pc;
  logic                 fetch_en;
  INST_Q                if_inst_in;

  modport master (
    input  inst_queue_full, branch_incorrect,
    input  branch_target_pc, bp_taken, bp_target,
    input  Imem2proc_response, Imem2proc_data,
    input  Imem2proc_tag,
    output proc2Imem_command, proc2Imem_addr,
    output fetch_pc, fetch_en, if_inst_in
  );

  modport slave (
    output inst_queue_full, branch_incorrect,
    output branch_target_pc, bp_taken, bp_target,
    output Imem2proc_response, Imem2proc_data,
    output Imem2proc_tag,
    input  proc2Imem_command, proc2Imem_addr,
    input  fetch_pc, fetch_en, if_inst_in
  );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps one 64-bit line, one outstanding
// imem request, and hands one instruction per cycle to the IQ.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_TAG_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    MISS  = 2'd0,
    WAIT  = 2'd1,
    HIT   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [63:0]          pc, pc_n;
  logic [60:0]          line_addr, la_n;
  logic [63:0]          line_data, ld_n;
  logic                 line_valid, lv_n;
  logic [MEM_TAG_W-1:0] req_tag, tag_n;

  logic        hit, tag_match, deliver, bi;
  logic [63:0] npc, pred_pc;
  bus_cmd_t    cmd;

  assign bi        = bus.branch_incorrect;
  assign hit       = line_valid && (line_addr == pc[63:3]);
  assign tag_match = (|req_tag) && (bus.Imem2proc_tag == req_tag);
  assign npc       = pc + 64'd4;
  assign pred_pc   = bus.bp_taken ? bus.bp_target : npc;

  // State register; reset wins over everything else.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= MISS;
      pc         <= RESET_PC;
      line_addr  <= '0;
      line_data  <= '0;
      line_valid <= 1'b0;
      req_tag    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      line_addr  <= la_n;
      line_data  <= ld_n;
      line_valid <= lv_n;
      req_tag    <= tag_n;
    end
  end

  // Next state: request/fill/deliver, then a flush overrides PC and line.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    la_n    = line_addr;
    ld_n    = line_data;
    lv_n    = line_valid;
    tag_n   = req_tag;
    cmd     = BUS_NONE;
    deliver = 1'b0;
    unique case (state)
      MISS: begin
        cmd = BUS_LOAD;
        if (|bus.Imem2proc_response) begin
          tag_n   = bus.Imem2proc_response;
          state_n = bi ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (tag_match) begin
          tag_n = '0;
          if (bi) begin
            state_n = MISS;
          end else begin
            ld_n    = bus.Imem2proc_data;
            la_n    = pc[63:3];
            lv_n    = 1'b1;
            state_n = HIT;
          end
        end else if (bi) begin
          state_n = DRAIN;
        end
      end
      HIT: begin
        if (bi || !hit) begin
          state_n = MISS;
        end else if (!bus.inst_queue_full) begin
          deliver = 1'b1;
          pc_n    = pred_pc;
          state_n = (line_addr == pred_pc[63:3]) ? HIT : MISS;
        end
      end
      DRAIN: begin
        if (tag_match) begin
          tag_n   = '0;
          state_n = MISS;
        end
      end
      default: state_n = MISS;
    endcase
    if (bi) begin
      pc_n = bus.branch_target_pc;
      lv_n = 1'b0;
    end
  end

  // Outputs; reset forces an idle bus and a NOOP bundle.
  always_comb begin
    bus.if_inst_in    = '0;
    bus.if_inst_in.ir = `NOOP_INST;
    bus.fetch_en      = 1'b0;
    bus.proc2Imem_command = BUS_NONE;
    bus.proc2Imem_addr    = {pc[63:3], 3'b000};
    bus.fetch_pc          = pc;
    if (!reset) begin
      bus.proc2Imem_command = cmd;
      bus.fetch_en          = deliver;
      if (deliver) begin
        bus.if_inst_in.valid_inst = 1'b1;
        bus.if_inst_in.npc        = npc;
        bus.if_inst_in.ir         = pc[2] ? line_data[63:32]
                                          : line_data[31:0];
        bus.if_inst_in.branch_inst.pc         = pc;
        bus.if_inst_in.branch_inst.pred_pc    = pred_pc;
        bus.if_inst_in.branch_inst.prediction = bus.bp_taken;
      end
    end
  end

endmodule
